// File: rtl/mem_pkg.sv
// mem_pkg: shared word geometry and responder state encoding for the mem_responder slice
package mem_pkg;
  localparam int XLEN = 64;
  localparam int WORD_OFFSET = 3;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: DEPTH x 64 single-port array, synchronous write on we, combinational read of idx (clk, we, idx, wdata in; rdata out)
module mem_resp_ram import mem_pkg::*; #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);
  logic [XLEN-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;
  assign rdata = mem[idx];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory slave FSM (clk, rst_n, PVALID/PADDR/HWRITE/PDATA in; HRDATA/HREADY/HRESP out); define MEM_RESPONDER_ERR_EN for out-of-range error responses
module mem_responder import mem_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PVALID,
  input  logic [XLEN-1:0] PADDR,
  input  logic            HWRITE,
  input  logic [XLEN-1:0] PDATA,
  output logic [XLEN-1:0] HRDATA,
  output logic            HREADY,
  output logic            HRESP
);
  localparam int AW = $clog2(DEPTH);
  state_t state;
  logic [3:0] cnt;
  logic [XLEN-1:0] addr_q, data_q, rd_q, rdata, a_addr, a_data;
  logic wr_q, err_q, accept, go_resp, a_wr, a_err, we, unused_bits;
  assign accept = PVALID && state != BUSY;
  assign go_resp = (WAIT_CYCLES == 0) ? accept : (state == BUSY && cnt == '0);
  assign a_addr = (WAIT_CYCLES == 0) ? PADDR : addr_q;
  assign a_data = (WAIT_CYCLES == 0) ? PDATA : data_q;
  assign a_wr = (WAIT_CYCLES == 0) ? HWRITE : wr_q;
`ifdef MEM_RESPONDER_ERR_EN
  assign a_err = |a_addr[XLEN-1:WORD_OFFSET+AW];
  assign HRESP = state == RESP && err_q;
`else
  assign a_err = 1'b0;
  assign HRESP = 1'b0;
`endif
  assign we = rst_n && go_resp && a_wr && !a_err;
  assign unused_bits = ^{a_addr[WORD_OFFSET-1:0], a_addr[XLEN-1:WORD_OFFSET+AW]};
  mem_resp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(we),
    .idx(a_addr[WORD_OFFSET +: AW]),
    .wdata(a_data),
    .rdata(rdata)
  );
  always_ff @(posedge clk)
    if (accept) begin
      addr_q <= PADDR;
      data_q <= PDATA;
      wr_q <= HWRITE;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= accept ? (WAIT_CYCLES == 0 ? RESP : BUSY) : state == BUSY ? (cnt == '0 ? RESP : BUSY) : IDLE;
      cnt <= accept ? 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0) : (state == BUSY && cnt != '0) ? cnt - 4'd1 : cnt;
      if (go_resp) begin
        err_q <= a_err;
        if (!a_wr && !a_err) rd_q <= rdata;
      end
    end
  assign HREADY = state != BUSY;
  assign HRDATA = (state == RESP && err_q) ? '0 : rd_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder plus streaming and max-latency instances
module tb_mem_responder;
  localparam int W = 2;
`ifdef MEM_RESPONDER_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  typedef struct {
    int due;
    logic [63:0] rd;
    logic resp;
    logic [63:0] hold;
  } exp_t;
  logic clk, rst_n, pvalid, pvalid0, pvalid15, hwrite;
  logic [63:0] paddr, pdata;
  logic [63:0] hrdata, hrdata0, hrdata15;
  logic hready, hready0, hready15, hresp, hresp0, hresp15;
  int total, bad, cyc;
  bit chk_en;
  logic [63:0] model [1024];
  logic [63:0] m_last, last_rd;
  exp_t q[$];
  exp_t e;
  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .PVALID(pvalid), .PADDR(paddr), .HWRITE(hwrite), .PDATA(pdata),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
  );
  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .PVALID(pvalid0), .PADDR(paddr), .HWRITE(hwrite), .PDATA(pdata),
    .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
  );
  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .PVALID(pvalid15), .PADDR(paddr), .HWRITE(hwrite), .PDATA(pdata),
    .HRDATA(hrdata15), .HREADY(hready15), .HRESP(hresp15)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic nedge();
    @(negedge clk);
    #1;
  endtask
  // Scoreboard: responses are matched purely on the cycle they are due.
  always @(negedge clk)
    if (chk_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("resp_hready", hready, 1);
        chk("resp_hrdata", hrdata, e.rd);
        chk("resp_hresp", hresp, e.resp);
        last_rd = e.hold;
      end else if (q.size() > 0 && cyc >= q[0].due - W) begin
        chk("busy_hready", hready, 0);
      end else begin
        chk("idle_hready", hready, 1);
        chk("idle_hrdata", hrdata, last_rd);
        chk("idle_hresp", hresp, 0);
      end
    end
  task automatic issue(bit wr, logic [63:0] a, logic [63:0] d);
    int n;
    int idx;
    bit er;
    exp_t x;
    n = 0;
    nedge();
    while (!hready && n < 40) begin
      pvalid = 1'($urandom_range(0, 1));
      hwrite = 1'($urandom_range(0, 1));
      paddr = {$urandom, $urandom};
      pdata = {$urandom, $urandom};
      n++;
      nedge();
    end
    if (!hready) begin
      chk("issue_timeout", hready, 1);
      return;
    end
    pvalid = 1'b1;
    hwrite = wr;
    paddr = a;
    pdata = d;
    idx = int'((a / 8) % 1024);
    er = ERR && (a / 8192) != 0;
    if (wr) begin
      x.rd = er ? 64'd0 : m_last;
      if (!er) model[idx] = d;
    end else begin
      x.rd = er ? 64'd0 : model[idx];
      if (!er) m_last = model[idx];
    end
    x.hold = m_last;
    x.resp = er;
    x.due = cyc + 1 + W;
    q.push_back(x);
  endtask
  task automatic gap(int n);
    repeat (n) begin
      nedge();
      pvalid = 1'b0;
    end
  endtask
  task automatic lat15(bit wr, logic [63:0] v);
    int n;
    nedge();
    pvalid15 = 1'b1;
    hwrite = wr;
    paddr = 64'h28;
    pdata = v;
    nedge();
    pvalid15 = 1'b0;
    n = 0;
    while (!hready15 && n < 40) begin
      n++;
      nedge();
    end
    chk(wr ? "lat15_wr_busy" : "lat15_rd_busy", n, 15);
    chk("lat15_hresp", hresp15, 0);
    if (!wr) chk("lat15_hrdata", hrdata15, v);
  endtask
  initial begin
    logic [63:0] old, a, v;
    logic [63:0] sd [4];
    int n;
    total = 0;
    bad = 0;
    cyc = 0;
    chk_en = 0;
    m_last = '0;
    last_rd = '0;
    pvalid = 0;
    pvalid0 = 0;
    pvalid15 = 0;
    hwrite = 0;
    paddr = '0;
    pdata = '0;
    rst_n = 0;
    repeat (3) nedge();
    rst_n = 1;
    chk("reset_hready", hready, 1);
    chk("reset_hrdata", hrdata, 0);
    chk("reset_hresp", hresp, 0);
    chk_en = 1;
    for (int i = 0; i < 32; i++) issue(1, 64'(i * 8), {$urandom, $urandom});
    issue(1, 64'h40, 64'hDEADBEEF_CAFEF00D);
    issue(0, 64'h40, 0);
    issue(0, 64'h45, 0);
    old = model[16];
    issue(1, 64'h80, 64'h1234);
    nedge();
    chk_en = 0;
    rst_n = 0;
    pvalid = 0;
    q.delete();
    nedge();
    rst_n = 1;
    chk("midrst_hready", hready, 1);
    chk("midrst_hrdata", hrdata, 0);
    chk("midrst_hresp", hresp, 0);
    model[16] = old;
    m_last = '0;
    last_rd = '0;
    chk_en = 1;
    issue(0, 64'h80, 0);
    issue(1, 64'h2000, 64'h5555_AAAA_0F0F_F0F0);
    issue(0, 64'h0, 0);
    issue(0, 64'h2000, 0);
    for (int i = 0; i < 300; i++) begin
      a = 64'($urandom_range(0, 31) * 8 + $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = a | (64'd1 << $urandom_range(13, 63));
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end
    nedge();
    pvalid = 0;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      n++;
      nedge();
    end
    chk("drain", q.size(), 0);
    chk_en = 0;
    for (int k = 0; k < 4; k++) sd[k] = {$urandom, $urandom} | 64'h1;
    for (int k = 0; k <= 8; k++) begin
      nedge();
      if (k > 0) begin
        chk("stream_hready", hready0, 1);
        chk("stream_hrdata", hrdata0, (k - 1) < 4 ? 64'd0 : sd[k - 5]);
        chk("stream_hresp", hresp0, 0);
      end
      pvalid0 = k < 8;
      hwrite = k < 4;
      paddr = 64'((k % 4) * 8);
      pdata = sd[k % 4];
    end
    v = {$urandom, $urandom};
    lat15(1, v);
    lat15(0, v);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, storage depth in 64-bit words; a power of two, at least 2.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per access; range 0..15.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-005 SHALL have port PVALID, input, 1 bit, request strobe from the arbitrated memory port.
REQ-006 SHALL have port PADDR, input, 64 bits, byte address of the request.
REQ-007 SHALL have port HWRITE, input, 1 bit, request direction: 1 write, 0 read.
REQ-008 SHALL have port PDATA, input, 64 bits, write data.
REQ-009 SHALL have port HRDATA, output, 64 bits, read data.
REQ-010 SHALL have port HREADY, output, 1 bit, ready/response-valid.
REQ-011 SHALL have port HRESP, output, 1 bit, error response.

Function
REQ-012 SHALL implement three states: IDLE, BUSY and RESP.
REQ-013 SHALL drive HREADY=1 in IDLE and RESP and HREADY=0 in BUSY.
REQ-014 SHALL accept a request in IDLE or RESP when PVALID=1, latching PADDR, HWRITE and PDATA at that edge; PVALID=0 leads to IDLE.
REQ-015 SHALL, on acceptance, enter BUSY with wait counter = WAIT_CYCLES-1 when WAIT_CYCLES>0, else enter RESP directly.
REQ-016 SHALL decrement the counter each BUSY cycle and enter RESP on the cycle the counter is 0.
REQ-017 SHALL meet the latency rule: RESP occurs exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-018 SHALL hold RESP for exactly one cycle.
REQ-019 SHALL commit a write to the array on the edge entering RESP.
REQ-020 SHALL present read data on HRDATA during RESP, and hold the last read value at all other times.
REQ-021 SHALL leave HRDATA unchanged on a write response.
REQ-022 SHALL support back-to-back requests: a request accepted in RESP yields the next RESP after WAIT_CYCLES+1 cycles with no idle gap; with WAIT_CYCLES=0 this gives one access per cycle.
REQ-023 SHALL return the just-written data for a read following a write to the same address (read-after-write).
REQ-024 SHALL compute the word index from PADDR[3+log2(DEPTH)-1:3] and ignore PADDR[2:0].
REQ-025 SHALL ignore PVALID while in BUSY; the upstream arbiter stalls on HREADY=0.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, set state to IDLE, the counter to 0, HRDATA to 0 and HRESP to 0, leaving HREADY=1.
REQ-027 SHALL drop an in-flight request on reset asserted mid-access (BUSY) with no array write.
REQ-028 SHALL leave array contents unchanged by reset.

Configuration
REQ-029 SHALL, with macro MEM_RESPONDER_ERR_EN defined, treat a request with nonzero PADDR[63:3+log2(DEPTH)] as out of range.
REQ-030 SHALL, for an out-of-range request, suppress the write, drive HRDATA=0 and HRESP=1 for its RESP cycle only, and keep the normal latency.
REQ-031 SHALL, without MEM_RESPONDER_ERR_EN, alias out-of-range addresses by wrapping on the index bits and tie HRESP to 0.

Structure
REQ-032 SHALL place in shared package mem_pkg: the state enumeration (IDLE/BUSY/RESP), XLEN=64 and WORD_OFFSET=3.
REQ-033 SHALL implement storage as one sub-module, mem_resp_ram: single-port synchronous array, DEPTH x 64, write enable plus index.
REQ-034 SHALL keep the FSM and counter in mem_responder.

Verification
REQ-035 SHALL cover a basic read/write round trip: write 0xDEADBEEF_CAFEF00D to 0x40, then read 0x40 -> HRDATA=0xDEADBEEF_CAFEF00D; HREADY low 2 cycles per access at WAIT_CYCLES=2.
REQ-036 SHALL cover streaming at WAIT_CYCLES=0: PVALID held high for 4 reads of 0x0, 0x8, 0x10, 0x18 -> 4 consecutive RESP cycles, HREADY never 0.
REQ-037 SHALL cover address-offset handling: read 0x45 after writing 0x40 -> same data; PADDR[2:0] ignored.
REQ-038 SHALL cover reset mid-access: rst_n=0 during BUSY of a write of 0x1234 to 0x80 -> state IDLE, HREADY=1, HRDATA=0; subsequent read of 0x80 returns the prior contents.
REQ-039 SHALL cover the error path with ERR_EN, DEPTH=1024: write to 0x2000 -> HRESP=1 for one cycle, array unchanged; without ERR_EN -> write lands at index 0 (aliased to 0x0), HRESP=0.
REQ-040 SHALL cover maximum latency at WAIT_CYCLES=15: a read response arrives exactly 16 cycles after acceptance.
